// File: rtl/pin_expand_seq.sv
// pin_expand_seq: iterative bit-deposit engine.
// Scatters the low-order bits of `data` into the positions selected by
// `mask`. It handles one mask bit per cycle and uses valid/ready
// handshakes on both the request side and the result side.
module pin_expand_seq #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    used
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] d_reg, d_next;      // remaining source bits, next one at bit 0
    logic [WIDTH-1:0] m_reg, m_next;      // remaining mask bits, current one at bit 0
    logic [WIDTH-1:0] r_reg, r_next;      // result under construction
    logic [IW-1:0]    idx_reg, idx_next;  // result position of m_reg[0]
    logic [CW-1:0]    used_reg, used_next;
    logic [WIDTH-1:0] wr_sel;             // one-hot decode of idx_reg

    // One-hot select of the destination bit for this RUN cycle.
    // idx_reg never points past WIDTH-1, because the mask runs out first.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = (idx_reg == IW'(gi));
    end

    // Next-state and datapath update for the three-state FSM.
    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        m_next     = m_reg;
        r_next     = r_reg;
        idx_next   = idx_reg;
        used_next  = used_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    d_next    = data;
                    m_next    = mask;
                    r_next    = '0;
                    idx_next  = '0;
                    used_next = '0;
                    // An empty mask has nothing to deposit, so go straight to DONE.
                    state_next = (mask == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (m_reg[0]) begin
                    r_next    = r_reg | (wr_sel & {WIDTH{d_reg[0]}});
                    d_next    = d_reg >> 1;
                    used_next = used_reg + CW'(1);
                end
                m_next   = m_reg >> 1;
                idx_next = idx_reg + IW'(1);
                // Leave RUN early once no selected positions remain above this one.
                if ((m_reg >> 1) == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset returns the engine to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers. Reset clears them, which also clears result/used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg    <= '0;
            m_reg    <= '0;
            r_reg    <= '0;
            idx_reg  <= '0;
            used_reg <= '0;
        end else begin
            d_reg    <= d_next;
            m_reg    <= m_next;
            r_reg    <= r_next;
            idx_reg  <= idx_next;
            used_reg <= used_next;
        end
    end

    // Handshake flags are decoded only from registered state.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = r_reg;
    assign used      = used_reg;

endmodule

// File: tb/tb_pin_expand_seq.sv
// Self-checking bench for pin_expand_seq.
// Runs directed cases and then randomized traffic. All checks compare
// against a plain deposit/compress model kept inside this bench.
module tb_pin_expand_seq;
    localparam int W   = 16;
    localparam int CW  = $clog2(W + 1);
    localparam int NTX = 1500;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data;
    logic [W-1:0]  mask;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [CW-1:0] used;

    int total = 0;
    int bad   = 0;

    pin_expand_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .used      (used)
    );

    always #5 clk = ~clk;

    // Reference deposit: the k-th set mask bit receives data bit k.
    function automatic logic [W-1:0] deposit(input logic [W-1:0] d, input logic [W-1:0] m);
        logic [W-1:0] res;
        int k;
        res = '0;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                res[i] = d[k];
                k++;
            end
        end
        return res;
    endfunction

    // Reference compress, used to check that deposit inverts it.
    function automatic logic [W-1:0] compress(input logic [W-1:0] v, input logic [W-1:0] m);
        logic [W-1:0] res;
        int k;
        res = '0;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                res[k] = v[i];
                k++;
            end
        end
        return res;
    endfunction

    // Expected number of RUN cycles: index of the highest set bit, plus one.
    function automatic int run_len(input logic [W-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) n = i + 1;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request. out_ready is held low for `hold` cycles in DONE.
    task automatic run_txn(input logic [W-1:0] d, input logic [W-1:0] m,
                           input int hold, input string tag);
        logic [W-1:0] exp_r;
        int           exp_u;
        int           n;
        exp_r = deposit(d, m);
        exp_u = $countones(m);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        data = d; mask = m; in_valid = 1'b1; out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        data = W'($urandom);
        mask = W'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(run_len(m)));
        check({tag, " result"}, 32'(result), 32'(exp_r));
        check({tag, " used"}, 32'(used), 32'(exp_u));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            data = W'($urandom);
            mask = W'($urandom);
            step();
            check({tag, " bp result"}, 32'(result), 32'(exp_r));
            check({tag, " bp used"}, 32'(used), 32'(exp_u));
            check({tag, " bp in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " bp out_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, " back idle"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " result held"}, 32'(result), 32'(exp_r));
    endtask

    initial begin
        logic [W-1:0] qr[$];
        int           qu[$];
        int           accepts;
        int           outs;
        int           cyc;
        int           sh;
        logic [31:0]  m32;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data = '0; mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset used", 32'(used), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Spec example, with the compress inverse checked as well.
        run_txn(16'h001B, 16'h4945, 0, "ex");
        check("ex value", 32'(result), 32'h0905);
        check("ex compress", 32'(compress(result, 16'h4945)), 32'h001B);

        run_txn(16'hFFFF, 16'h0000, 0, "mask0");
        run_txn(16'hA5C3, 16'hFFFF, 0, "maskff");
        run_txn(16'hFFFE, 16'h0001, 0, "mask1");

        // Backpressure: hold out_ready low for 10 cycles in DONE.
        run_txn(16'h1234, 16'h0F0F, 10, "bp");
        step();
        check("bp no phantom accept", 32'(in_ready), 32'd1);

        // Reset asserted five cycles into RUN.
        data = 16'h001B; mask = 16'h4945; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("midrun busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrun rst out_valid", 32'(out_valid), 32'd0);
        check("midrun rst in_ready", 32'(in_ready), 32'd1);
        check("midrun rst result", 32'(result), 32'd0);
        check("midrun rst used", 32'(used), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post rst no out_valid", 32'(out_valid), 32'd0);
        run_txn(16'h00C5, 16'h8421, 0, "post rst");

        // Randomized traffic scoreboarded against the model.
        accepts = 0; outs = 0; cyc = 0;
        while ((accepts < NTX || qr.size() > 0) && cyc < 60000) begin
            in_valid  = (accepts < NTX) && ($urandom_range(0, 3) != 0);
            sh        = $urandom_range(0, W);
            m32       = $urandom & ((32'h1 << sh) - 32'h1);
            mask      = m32[W-1:0];
            data      = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                qr.push_back(deposit(data, mask));
                qu.push_back($countones(mask));
                accepts++;
            end
            if (out_valid && out_ready) begin
                check("rand pending", 32'(qr.size() > 0), 32'd1);
                if (qr.size() > 0) begin
                    check("rand result", 32'(result), 32'(qr[0]));
                    check("rand used", 32'(used), 32'(qu[0]));
                    void'(qr.pop_front());
                    void'(qu.pop_front());
                end
                outs++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand outputs", 32'(outs), 32'(NTX));
        check("rand accepts", 32'(accepts), 32'(NTX));
        check("rand queue empty", 32'(qr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
